// File: rtl/rifl_pkg.sv
// -----------------------------------------------------------------------------
// rifl_pkg
// Shared definitions for the RIFL transmit path: frame meta codes, frame field
// positions derived from FRAME_WIDTH / PAYLOAD_WIDTH, and a byte-enable
// popcount helper used by the frame packer and the tkeep contiguity check.
// No ports (package).
// -----------------------------------------------------------------------------
package rifl_pkg;

    localparam logic [1:0] META_IDLE     = 2'b00;
    localparam logic [1:0] META_ABV      = 2'b01;
    localparam logic [1:0] META_EOP      = 2'b10;
    localparam logic [1:0] META_EOP_FULL = 2'b11;

    // The top two frame bits are left to the downstream frame-type stage,
    // so meta sits just below them and the payload follows.
    function automatic int metaMsb(input int frameWidth);
        return frameWidth - 3;
    endfunction

    function automatic int payloadMsb(input int frameWidth);
        return frameWidth - 5;
    endfunction

    function automatic int countMsb(input int frameWidth, input int payloadWidth);
        return frameWidth - 5 - payloadWidth;
    endfunction

    // Byte enables are at most 255 wide, so a 256-bit argument covers every
    // legal configuration; callers zero-extend.
    function automatic logic [8:0] popcount(input logic [255:0] v);
        logic [8:0] n;
        n = '0;
        for (int i = 0; i < 256; i++) begin
            n = n + 9'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tx_dwidth_conv_if.sv
// -----------------------------------------------------------------------------
// tx_dwidth_conv_if
// AXI-Stream payload interface feeding the RIFL transmit width converter.
//   tdata  : payload word, byte 0 in the MSBs
//   tkeep  : byte enables, MSB-contiguous
//   tlast  : end of packet
//   tvalid : word available (master drives)
//   tready : word accepted when high with tvalid (slave drives)
// Modports: master (source side), slave (converter side).
// -----------------------------------------------------------------------------
interface tx_dwidth_conv_if #(
    parameter int PAYLOAD_WIDTH = 240
) ();

    logic [PAYLOAD_WIDTH-1:0]   tdata;
    logic [PAYLOAD_WIDTH/8-1:0] tkeep;
    logic                       tlast;
    logic                       tvalid;
    logic                       tready;

    modport master (
        output tdata, tkeep, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tvalid,
        output tready
    );

endinterface

// File: rtl/tx_dwidth_conv_pack.sv
// -----------------------------------------------------------------------------
// tx_frame_pack
// Combinational word-to-frame builder. Produces one FRAME_WIDTH frame with the
// meta code, masked payload and byte count the receive converter decodes.
//   valid_i : a word is loaded; low produces an all-zero idle frame
//   tdata_i : payload, byte 0 in the MSBs
//   tkeep_i : byte enables
//   tlast_i : end of packet
//   frame_o : assembled frame, low bits left zero for the CRC stage
// -----------------------------------------------------------------------------
module tx_frame_pack
    import rifl_pkg::*;
#(
    parameter int FRAME_WIDTH   = 256,
    parameter int PAYLOAD_WIDTH = 240
) (
    input  logic                       valid_i,
    input  logic [PAYLOAD_WIDTH-1:0]   tdata_i,
    input  logic [PAYLOAD_WIDTH/8-1:0] tkeep_i,
    input  logic                       tlast_i,
    output logic [FRAME_WIDTH-1:0]     frame_o
);

    localparam int KEEP_W      = PAYLOAD_WIDTH / 8;
    localparam int META_MSB    = metaMsb(FRAME_WIDTH);
    localparam int PAYLOAD_MSB = payloadMsb(FRAME_WIDTH);
    localparam int COUNT_MSB   = countMsb(FRAME_WIDTH, PAYLOAD_WIDTH);

    logic [PAYLOAD_WIDTH-1:0] maskedData;
    logic [1:0]               meta;
    logic [7:0]               byteCount;
    logic [8:0]               keepOnes;

    // A partial last word reports how many leading bytes are real; a full
    // last word gets its own meta code so the receiver need not count.
    always_comb begin
        frame_o    = '0;
        maskedData = '0;
        meta       = META_IDLE;
        byteCount  = '0;
        keepOnes   = popcount({{(256-KEEP_W){1'b0}}, tkeep_i});
        for (int i = 0; i < KEEP_W; i++) begin
            maskedData[8*i +: 8] = tkeep_i[i] ? tdata_i[8*i +: 8] : 8'h00;
        end
        if (valid_i) begin
            if (!tlast_i) begin
                meta      = META_ABV;
                byteCount = 8'(KEEP_W);
            end else if (&tkeep_i) begin
                meta      = META_EOP_FULL;
                byteCount = 8'(KEEP_W);
            end else begin
                meta      = META_EOP;
                byteCount = keepOnes[7:0];
            end
            frame_o[META_MSB -: 2]                = meta;
            frame_o[PAYLOAD_MSB -: PAYLOAD_WIDTH] = maskedData;
            frame_o[COUNT_MSB -: 8]               = byteCount;
        end
    end

endmodule

// File: rtl/tx_dwidth_conv.sv
// -----------------------------------------------------------------------------
// tx_dwidth_conv
// Transmit frame packer and width converter. One payload word (or an idle
// frame) becomes one FRAME_WIDTH frame, sent as FRAME_WIDTH/DWIDTH beats,
// MSB slice first, advancing only on beat_en.
//   clk, rst_n : clock, asynchronous active-low reset
//   s_axis     : AXI-Stream payload input (slave modport)
//   beat_en    : downstream consumes one beat this cycle
//   dout       : beat data
//   dout_sof   : beat is the first slice of a frame
//   dout_valid : dout/dout_sof updated this cycle (registered beat_en)
// Build option RIFL_TX_SKID_BUF_EN: adds a one-entry input buffer with a
// registered tready; otherwise tready is beat_en at a frame boundary.
// -----------------------------------------------------------------------------
module tx_dwidth_conv
    import rifl_pkg::*;
#(
    parameter int DWIDTH        = 64,
    parameter int FRAME_WIDTH   = 256,
    parameter int PAYLOAD_WIDTH = 240
) (
    input  logic              clk,
    input  logic              rst_n,
    tx_dwidth_conv_if.slave   s_axis,
    input  logic              beat_en,
    output logic [DWIDTH-1:0] dout,
    output logic              dout_sof,
    output logic              dout_valid
);

    localparam int RATIO  = FRAME_WIDTH / DWIDTH;
    localparam int CNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int KEEP_W = PAYLOAD_WIDTH / 8;

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [FRAME_WIDTH-1:0]   frame_q, frame_d;
    logic [DWIDTH-1:0]        dout_q, dout_d;
    logic                     sof_q, sof_d;
    logic                     valid_q;
    logic                     boundary;
    logic                     accept;
    logic                     packValid;
    logic [PAYLOAD_WIDTH-1:0] packData;
    logic [KEEP_W-1:0]        packKeep;
    logic                     packLast;
    logic [FRAME_WIDTH-1:0]   packedFrame;
    logic [DWIDTH-1:0]        slices [RATIO];

    assign boundary = beat_en && (cnt_q == '0);

`ifdef RIFL_TX_SKID_BUF_EN
    logic                     bufFull_q, bufFull_d;
    logic                     tready_q;
    logic [PAYLOAD_WIDTH-1:0] bufData_q;
    logic [KEEP_W-1:0]        bufKeep_q;
    logic                     bufLast_q;

    assign s_axis.tready = tready_q;
    assign accept        = s_axis.tvalid && tready_q;
    // A boundary drain and a new fill in the same cycle leave the buffer
    // full holding the newer word.
    assign bufFull_d     = accept || (bufFull_q && !boundary);
    assign packValid     = bufFull_q;
    assign packData      = bufData_q;
    assign packKeep      = bufKeep_q;
    assign packLast      = bufLast_q;

    // Skid buffer storage and the registered ready that tracks its occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bufFull_q <= 1'b0;
            tready_q  <= 1'b0;
            bufData_q <= '0;
            bufKeep_q <= '0;
            bufLast_q <= 1'b0;
        end else begin
            bufFull_q <= bufFull_d;
            tready_q  <= !bufFull_d;
            if (accept) begin
                bufData_q <= s_axis.tdata;
                bufKeep_q <= s_axis.tkeep;
                bufLast_q <= s_axis.tlast;
            end
        end
    end
`else
    // Ready only when the word can go straight into the next frame; gated by
    // rst_n so it reads low throughout reset.
    assign s_axis.tready = rst_n && boundary;
    assign accept        = s_axis.tvalid && s_axis.tready;
    assign packValid     = accept;
    assign packData      = s_axis.tdata;
    assign packKeep      = s_axis.tkeep;
    assign packLast      = s_axis.tlast;
`endif

    tx_frame_pack #(
        .FRAME_WIDTH   (FRAME_WIDTH),
        .PAYLOAD_WIDTH (PAYLOAD_WIDTH)
    ) u_pack (
        .valid_i (packValid),
        .tdata_i (packData),
        .tkeep_i (packKeep),
        .tlast_i (packLast),
        .frame_o (packedFrame)
    );

    for (genvar k = 0; k < RATIO; k++) begin : g_slice
        assign slices[k] = frame_q[FRAME_WIDTH-1-k*DWIDTH -: DWIDTH];
    end

    // Boundary beats take slice 0 straight from the packer so the new frame
    // leaves without waiting for frame_q; later beats read the stored frame.
    always_comb begin
        cnt_d   = cnt_q;
        frame_d = frame_q;
        dout_d  = dout_q;
        sof_d   = sof_q;
        if (beat_en) begin
            cnt_d = (cnt_q == CNT_W'(RATIO-1)) ? '0 : cnt_q + CNT_W'(1);
            if (cnt_q == '0) begin
                frame_d = packedFrame;
                dout_d  = packedFrame[FRAME_WIDTH-1 -: DWIDTH];
                sof_d   = 1'b1;
            end else begin
                dout_d  = slices[cnt_q];
                sof_d   = 1'b0;
            end
        end
    end

    // Beat counter, held frame and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            frame_q <= '0;
            dout_q  <= '0;
            sof_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            dout_q  <= dout_d;
            sof_q   <= sof_d;
            valid_q <= beat_en;
        end
    end

    assign dout       = dout_q;
    assign dout_sof   = sof_q;
    assign dout_valid = valid_q;

    // Accepted byte enables must be a run of ones from the MSB.
    logic [8:0]        keepOnes;
    logic [KEEP_W-1:0] keepExpect;
    assign keepOnes   = popcount({{(256-KEEP_W){1'b0}}, s_axis.tkeep});
    assign keepExpect = ~({KEEP_W{1'b1}} >> keepOnes);

    assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> (s_axis.tkeep == keepExpect));

endmodule

// File: tb/tb_tx_dwidth_conv.sv
// -----------------------------------------------------------------------------
// tb_tx_dwidth_conv
// Self-checking bench for tx_dwidth_conv in its default build. A frame-level
// model (integer beat index, arithmetic frame assembly) predicts dout,
// dout_sof, dout_valid and tready every cycle; a few literal checks pin the
// model's frame fields and the DUT's reset and handshake behaviour.
// -----------------------------------------------------------------------------
module tb_tx_dwidth_conv;

    localparam int DW    = 64;
    localparam int FW    = 256;
    localparam int PW    = 240;
    localparam int KW    = PW / 8;
    localparam int RATIO = FW / DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          beat_en = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_sof;
    logic          dout_valid;

    int errors     = 0;
    int checks     = 0;
    int sofSeen    = 0;
    int acceptSeen = 0;
    int beatMode   = 0;

    tx_dwidth_conv_if #(.PAYLOAD_WIDTH(PW)) axisIf ();

    tx_dwidth_conv #(
        .DWIDTH        (DW),
        .FRAME_WIDTH   (FW),
        .PAYLOAD_WIDTH (PW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_axis     (axisIf),
        .beat_en    (beat_en),
        .dout       (dout),
        .dout_sof   (dout_sof),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Frame from first principles: meta in bits 253:252, payload below it,
    // byte count below the payload, everything else zero.
    function automatic logic [255:0] modelFrame(input bit loaded, input logic [PW-1:0] data,
                                                input logic [KW-1:0] keep, input bit last);
        logic [255:0] f;
        logic [PW-1:0] pay;
        int ones;
        int meta;
        int count;
        f = '0;
        pay = '0;
        ones = 0;
        if (!loaded) return f;
        for (int i = 0; i < KW; i++) begin
            if (keep[i]) begin
                ones++;
                pay[8*i +: 8] = data[8*i +: 8];
            end
        end
        if (!last) begin
            meta = 1; count = KW;
        end else if (ones == KW) begin
            meta = 3; count = KW;
        end else begin
            meta = 2; count = ones;
        end
        f = (256'(meta) << (FW-4)) | (256'(pay) << (FW-4-PW)) | (256'(count) << (FW-12-PW));
        return f;
    endfunction

    // Beat_en source: 0 off, 1 held high, 2 toggling every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (beatMode)
                1:       beat_en = 1'b1;
                2:       beat_en = ~beat_en;
                default: beat_en = 1'b0;
            endcase
        end
    end

    // Model and per-cycle compare, sampled on the falling edge.
    logic [DW-1:0]  expDout  = '0;
    bit             expSof   = 1'b0;
    bit             expValid = 1'b0;
    bit             expReady;
    int             beatIdx  = 0;
    int             k;
    logic [255:0]   curFrame = '0;
    logic [255:0]   shifted;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expDout = '0; expSof = 1'b0; expValid = 1'b0;
            end
            checkOutput("dout", 256'(dout), 256'(expDout));
            checkOutput("dout_sof", 256'(dout_sof), 256'(expSof));
            checkOutput("dout_valid", 256'(dout_valid), 256'(expValid));
            k = beatIdx % RATIO;
            expReady = rst_n && beat_en && (k == 0);
            checkOutput("tready", 256'(axisIf.tready), 256'(expReady));
            if (axisIf.tvalid && axisIf.tready) acceptSeen++;
            if (dout_sof) sofSeen++;
            if (!rst_n) begin
                beatIdx = 0; curFrame = '0;
                expDout = '0; expSof = 1'b0; expValid = 1'b0;
            end else begin
                expValid = beat_en;
                if (beat_en) begin
                    if (k == 0) begin
                        curFrame = modelFrame(axisIf.tvalid, axisIf.tdata, axisIf.tkeep, axisIf.tlast);
                        expSof = 1'b1;
                    end else begin
                        expSof = 1'b0;
                    end
                    shifted = curFrame >> (FW - DW*(k+1));
                    expDout = shifted[DW-1:0];
                    beatIdx++;
                end
            end
        end
    end

    // Present one word and hold it until the handshake completes.
    task automatic applyStimulus(input logic [PW-1:0] data, input logic [KW-1:0] keep, input bit last);
        bit hit;
        bit ok;
        ok = 1'b0;
        axisIf.tdata  = data;
        axisIf.tkeep  = keep;
        axisIf.tlast  = last;
        axisIf.tvalid = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            hit = axisIf.tready;
            @(posedge clk);
            #1;
            if (hit) begin
                ok = 1'b1;
                break;
            end
        end
        axisIf.tvalid = 1'b0;
        checkOutput("handshake", 256'(ok), 256'(1));
    endtask

    logic [PW-1:0]  incData;
    logic [255:0]   f;
    int             s0;
    bit             sofFound;

    initial begin
        rst_n         = 1'b0;
        axisIf.tdata  = '0;
        axisIf.tkeep  = '0;
        axisIf.tlast  = 1'b0;
        axisIf.tvalid = 1'b0;
        beatMode      = 1;
        for (int i = 0; i < KW; i++) incData[PW-1-8*i -: 8] = 8'(i + 1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetDout", 256'(dout), 256'(0));
        checkOutput("resetTready", 256'(axisIf.tready), 256'(0));
        rst_n = 1'b1;

        // Idle frames: two sofs in eight beats.
        s0 = sofSeen;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("idleSofCount", 256'(sofSeen - s0), 256'(2));

        // Literal pins on the model's frame fields.
        f = modelFrame(1'b1, incData, 30'h3FFFFFFF, 1'b0);
        checkOutput("pinAbvHdr", 256'(f[255:252]), 256'(4'h1));
        checkOutput("pinAbvCount", 256'(f[11:4]), 256'(8'h1E));
        checkOutput("pinAbvPayload", 256'(f[251:12]), 256'(incData));
        f = modelFrame(1'b1, incData, 30'h3FFF8000, 1'b1);
        checkOutput("pinEopHdr", 256'(f[255:252]), 256'(4'h2));
        checkOutput("pinEopCount", 256'(f[11:4]), 256'(8'h0F));
        checkOutput("pinEopLowZero", 256'(f[131:12]), 256'(0));
        f = modelFrame(1'b1, incData, 30'h3FFFFFFF, 1'b1);
        checkOutput("pinFullHdr", 256'(f[255:252]), 256'(4'h3));
        checkOutput("pinFullCount", 256'(f[11:4]), 256'(8'h1E));
        f = modelFrame(1'b1, incData, 30'h0, 1'b1);
        checkOutput("pinZeroCount", 256'(f[11:0]), 256'(0));

        applyStimulus(incData, 30'h3FFFFFFF, 1'b0);
        applyStimulus(incData, 30'h3FFF8000, 1'b1);

        // Back-to-back three-word packet.
        applyStimulus(~incData, 30'h3FFFFFFF, 1'b0);
        applyStimulus({incData[PW-9:0], 8'hA5}, 30'h3FFFFFFF, 1'b0);
        applyStimulus(incData ^ {KW{8'h5A}}, 30'h3FFFFFFF, 1'b1);
        repeat (6) @(posedge clk);
        #1;

        // Stalled beats mid-frame; zero-byte end word.
        beatMode = 2;
        applyStimulus(incData, 30'h0, 1'b1);
        repeat (16) @(posedge clk);
        #1;
        beatMode = 1;

        // Reset just after slice 1 of a frame leaves the output.
        sofFound = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (dout_sof) begin
                sofFound = 1'b1;
                break;
            end
        end
        checkOutput("sofBeforeReset", 256'(sofFound), 256'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midResetDout", 256'(dout), 256'(0));
        checkOutput("midResetSof", 256'(dout_sof), 256'(0));
        checkOutput("midResetValid", 256'(dout_valid), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(~incData, 30'h3FFFFFFF, 1'b1);
        repeat (8) @(posedge clk);
        #1;

        checkOutput("acceptCount", 256'(acceptSeen), 256'(7));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_dwidth_conv.md
# tx_dwidth_conv

Transmit-side frame packer and width converter for the RIFL link. It accepts AXI-Stream payload words of PAYLOAD_WIDTH bits and builds one FRAME_WIDTH-bit frame per word, with the meta code and byte count in the fields the receive converter decodes. Each frame is emitted as FRAME_WIDTH/DWIDTH beats toward the scrambler/CRC/gearbox path. Beats advance only on the downstream `beat_en` strobe, and idle frames fill every slot with no payload.

## Interface
- DWIDTH, 64, output beat width; FRAME_WIDTH must be an integer multiple of it (ratio 1 is legal)
- FRAME_WIDTH, 256, frame width
- PAYLOAD_WIDTH, 240, payload bits per frame; multiple of 8; FRAME_WIDTH ≥ PAYLOAD_WIDTH+12; PAYLOAD_WIDTH/8 ≤ 255
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous assert, active-low
- s_axis_tdata  in  PAYLOAD_WIDTH  payload, byte 0 in the MSBs
- s_axis_tkeep  in  PAYLOAD_WIDTH/8  byte enables, MSB-contiguous
- s_axis_tlast  in  1  end of packet
- s_axis_tvalid  in  1  word available
- s_axis_tready  out  1  word accepted when high together with tvalid
- beat_en  in  1  downstream consumes one beat this cycle
- dout  out  DWIDTH  beat data, frame MSB slice first
- dout_sof  out  1  beat is the first slice of a frame
- dout_valid  out  1  dout/dout_sof are new this cycle

## Operation
- Frame layout, MSB first:
  - [F-1:F-2] = 2'b00, reserved for the downstream frame type.
  - [F-3:F-4] = meta.
  - [F-5 -: PAYLOAD_WIDTH] = payload.
  - [F-5-PAYLOAD_WIDTH -: 8] = byte count.
  - Remaining LSBs = 0; the CRC stage fills them.
- Meta and count:
  - No word loaded: meta 00 (idle), payload 0, count 0.
  - tlast=0: meta 01 (ABV), count = PAYLOAD_WIDTH/8.
  - tlast=1 with tkeep all ones: meta 11, count = PAYLOAD_WIDTH/8.
  - tlast=1 with tkeep partial: meta 10, count = popcount(tkeep), 0 allowed.
- Bytes with tkeep=0 are zeroed in the payload.
- Non-contiguous tkeep is a protocol violation. Count is still popcount, and an assertion fires in simulation.
- Beat counter `cnt`, width clog2(RATIO) (1 bit minimum). It increments on beat_en and wraps from RATIO-1 to 0.
- Frame boundary is beat_en with cnt==0:
  - A new frame is formed from the input (or idle) and stored in frame_q.
  - dout takes slice 0 and dout_sof=1.
- Other beat_en cycles: dout = frame_q slice cnt, dout_sof=0.
- dout_valid = registered beat_en.
- Without beat_en, dout, dout_sof and cnt hold.

## Timing
- Reset values: dout=0, dout_sof=0, dout_valid=0, cnt=0, frame_q=0, s_axis_tready=0 while rst_n low.
- Default build: s_axis_tready = beat_en && cnt==0, combinational.
  - The accepted word is on dout with dout_sof=1 one cycle later.
  - Slice k of that frame appears one cycle after the k-th subsequent beat_en.
- tvalid low at a boundary: an idle frame is sent and no word is dropped.
- beat_en stalled mid-frame: the frame resumes at the same slice; frame_q is not reloaded.
- Reset during a frame: the output is truncated; after release the first beat_en starts a fresh frame at slice 0.
- RATIO==1: every beat_en is a boundary; tready = beat_en.

## Configuration
- RIFL_TX_SKID_BUF_EN defined:
  - A one-entry input buffer is added and s_axis_tready = !buf_full, registered.
  - The buffer fills on tvalid&&tready and drains at a frame boundary.
  - Fill and drain in the same cycle keep it full with the new word.
  - Minimum acceptance-to-sof latency becomes 2 cycles.
  - The buffer resets empty.
- Undefined: the combinational tready path above, with no buffer.

## Structure
- rifl_pkg holds:
  - Meta code constants: META_IDLE=2'b00, META_ABV=2'b01, META_EOP=2'b10, META_EOP_FULL=2'b11.
  - Field offset localparams as functions of FRAME_WIDTH/PAYLOAD_WIDTH.
  - popcount function.
- Sub-module tx_frame_pack: combinational word→frame builder covering meta, count, byte masking and layout. It is reused by unit tests.

## Test plan
- Reset, beat_en held 1, tvalid 0 → repeating 4-beat idle frames: dout_sof pattern 1000, all dout=0.
- One word, tlast=0, tkeep=30'h3FFFFFFF, tdata=incrementing bytes → frame meta 01, count 30 (8'h1E), payload bits [251:12] equal tdata; tready high exactly one cycle.
- tlast=1, tkeep=30'h3FFF8000 (15 bytes) → meta 10, count 15, low 15 payload bytes zero.
- tlast=1, tkeep all ones → meta 11, count 30; back-to-back 3-word packet with beat_en=1 → frames contiguous, no idle between.
- beat_en toggled 1010… mid-frame → slices in order, dout_sof once per frame, no repeated or skipped slice.
- rst_n pulsed low after slice 1, then released → outputs 0 during reset; the next beat_en yields sof=1 with a new frame. With RIFL_TX_SKID_BUF_EN defined, the buffer is empty and tready is 1 after release.
